// File: rtl/flash_read_sequencer.sv
// flash_read_sequencer: single-word read sequencer for an asynchronous parallel
// NOR flash, with a one-entry last-word cache in front of it.
// A read miss runs SETUP -> ACCESS -> RECOVER -> RESP.
// A cache hit goes straight to RESP.
module flash_read_sequencer #(
    parameter int ACCESS_CYCLES   = 128,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        req_valid,
    input  logic [16:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic        rsp_ready,
    input  logic        flush,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic [16:0] A,
    input  logic [15:0] DQ,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RECOVER, RESP} state_t;

    localparam logic [7:0] ACCESS_LOAD   = 8'(ACCESS_CYCLES - 1);
    localparam logic [7:0] RECOVERY_LOAD = 8'(RECOVERY_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  cnt_reg;
    logic        ce_n_reg;
    logic        oe_n_reg;
    logic [16:0] a_reg;
    logic [15:0] rsp_data_reg;
    logic        cache_valid_reg;
    logic [16:0] cache_addr_reg;
    logic [15:0] cache_data_reg;
    logic        ready_en_reg;

    logic        accept;
    logic        hit;
    logic        cnt_zero;

    // ready_en_reg delays req_ready until the first clock edge after reset is released.
    assign req_ready = (state_reg == IDLE) && !flush && SIM_RST && ready_en_reg;
    assign accept    = req_valid && req_ready;
    assign hit       = cache_valid_reg && (req_addr == cache_addr_reg);
    assign cnt_zero  = (cnt_reg == 8'd0);

    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign busy      = (state_reg != IDLE);
    assign CE_n      = ce_n_reg;
    assign OE_n      = oe_n_reg;
    assign WE_n      = 1'b1;
    assign A         = a_reg;

    // Next-state logic for the read sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = hit ? RESP : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt_zero) state_next = RECOVER;
            RECOVER: if (cnt_zero) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the flash strobes.
    // The strobes are computed from state_next, so the pins come straight from flops.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            state_reg    <= IDLE;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ce_n_reg     <= (state_next != ACCESS);
            oe_n_reg     <= (state_next != ACCESS);
            ready_en_reg <= 1'b1;
        end
    end

    // The access counter reloads in SETUP.
    // The recovery counter reloads on the last ACCESS edge.
    // Both counters stop at zero.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                SETUP:   cnt_reg <= ACCESS_LOAD;
                ACCESS:  cnt_reg <= cnt_zero ? RECOVERY_LOAD : cnt_reg - 8'd1;
                RECOVER: if (!cnt_zero) cnt_reg <= cnt_reg - 8'd1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Address latch, response word, and last-word cache.
    // A flush on the capture edge still delivers DQ, but it leaves the cache invalid.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            a_reg           <= 17'd0;
            rsp_data_reg    <= 16'd0;
            cache_valid_reg <= 1'b0;
            cache_addr_reg  <= 17'd0;
            cache_data_reg  <= 16'd0;
        end else begin
            if (state_reg == IDLE && accept) begin
                if (hit) begin
                    rsp_data_reg <= cache_data_reg;
                end else begin
                    a_reg <= req_addr;
                end
            end
            if (state_reg == ACCESS && cnt_zero) begin
                rsp_data_reg    <= DQ;
                cache_data_reg  <= DQ;
                cache_addr_reg  <= a_reg;
                cache_valid_reg <= 1'b1;
            end
            if (flush) begin
                cache_valid_reg <= 1'b0;
            end
        end
    end

endmodule
